// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter. Accepts one parallel word through a
// valid/ready handshake and emits a single asynchronous frame:
// start bit (0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Bit timing comes from an internal baud counter
// running on the system clock.
//
// Ports
//   RST_clk      in   system clock, rising edge
//   RST_n        in   synchronous reset, active-high (legacy name)
//   tx_data      in   word to send, captured only on handshake
//   tx_valid     in   tx_data valid
//   tx_ready     out  block can accept a word this cycle (registered)
//   uart_tx_data out  serial line, idle high (registered)
//   uart_busy    out  high while a frame is on the line (registered)
//   tx_done      out  one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLK_DIV     = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 RST_clk,
    input  logic                 RST_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx_data,
    output logic                 uart_busy,
    output logic                 tx_done
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if ((PARITY_MODE < 0) || (PARITY_MODE > 2)) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
        logic p;
        p = ^data;
        if (PARITY_MODE == 1) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    state_t                state_q,  state_d;
    logic [BAUD_W-1:0]     baud_q,   baud_d;
    logic [BIT_W-1:0]      bit_q,    bit_d;
    logic [DATA_BITS-1:0]  shift_q,  shift_d;
    logic                  parity_q, parity_d;
    logic                  line_q,   line_d;
    logic                  busy_q,   busy_d;
    logic                  ready_q,  ready_d;
    logic                  done_q,   done_d;
    logic                  handshake_s;
    logic                  baud_end_s;

    // Next-state, counters, shift register and next output values.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        handshake_s = tx_valid && ready_q;
        baud_end_s  = (baud_q == BAUD_LAST);

        // Baud counter restarts at every bit boundary so each bit state
        // lasts exactly CLK_DIV cycles.
        if (state_q == ST_IDLE) begin
            baud_d = '0;
        end else if (baud_end_s) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_d  = ST_START;
                    shift_d  = tx_data;
                    parity_d = parity_bit(tx_data);
                    bit_d    = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered line
        // shows the start bit in the cycle right after the handshake.
        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = parity_d;
            default:   line_d = 1'b1;
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE) && !RST_n;
        done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge RST_clk) begin
        if (RST_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready     = ready_q;
    assign uart_tx_data = line_q;
    assign uart_busy    = busy_q;
    assign tx_done      = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Four transmitters (8N1, 8E1, 8O1, 7N2; CLK_DIV=4) share clock, reset and
// data. A frame-level model predicts the line, busy, ready and done of every
// instance each cycle; directed sends are recorded and pinned with
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int DIV = 4;

    int cfg_db [4] = '{8, 8, 8, 7};
    int cfg_pm [4] = '{0, 2, 1, 0};
    int cfg_sb [4] = '{1, 1, 1, 2};

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] line;
    logic [3:0] busy;
    logic [3:0] done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .RST_clk(clk), .RST_n(rst), .tx_data(din[7:0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .uart_tx_data(line[0]), .uart_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .RST_clk(clk), .RST_n(rst), .tx_data(din[7:0]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .uart_tx_data(line[1]), .uart_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
        .RST_clk(clk), .RST_n(rst), .tx_data(din[7:0]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .uart_tx_data(line[2]), .uart_busy(busy[2]), .tx_done(done[2]));
    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .RST_clk(clk), .RST_n(rst), .tx_data(din[6:0]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .uart_tx_data(line[3]), .uart_busy(busy[3]), .tx_done(done[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int          m_rem [4];
    int          m_len [4];
    logic [15:0] m_frame [4];
    logic        m_line [4];
    logic        m_busy [4];
    logic        m_ready [4];
    logic        m_done [4];
    logic [15:0] mf;
    int          mones;

    initial begin
        for (int i = 0; i < 4; i++) m_rem[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rst) begin
                    m_rem[i] = 0; m_line[i] = 1'b1; m_busy[i] = 1'b0;
                    m_ready[i] = 1'b0; m_done[i] = 1'b0;
                end else if (m_rem[i] > 0) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_line[i] = 1'b1; m_busy[i] = 1'b0; m_ready[i] = 1'b1; m_done[i] = 1'b1;
                    end else begin
                        m_line[i]  = m_frame[i][(m_len[i] * DIV - m_rem[i]) / DIV];
                        m_busy[i]  = 1'b1; m_ready[i] = 1'b0; m_done[i] = 1'b0;
                    end
                end else if (m_ready[i] && vld[i]) begin
                    mf    = 16'hFFFF;
                    mf[0] = 1'b0;
                    mones = 0;
                    for (int k = 0; k < cfg_db[i]; k++) begin
                        mf[1 + k] = din[k];
                        mones += int'(din[k]);
                    end
                    m_len[i] = 1 + cfg_db[i] + cfg_sb[i];
                    if (cfg_pm[i] != 0) begin
                        mf[1 + cfg_db[i]] = (cfg_pm[i] == 2) ? (mones % 2 == 1) : (mones % 2 == 0);
                        m_len[i] = m_len[i] + 1;
                    end
                    m_frame[i] = mf;
                    m_rem[i]   = m_len[i] * DIV;
                    m_line[i]  = mf[0]; m_busy[i] = 1'b1; m_ready[i] = 1'b0; m_done[i] = 1'b0;
                end else begin
                    m_line[i] = 1'b1; m_busy[i] = 1'b0; m_ready[i] = 1'b1; m_done[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("cmp_line%0d", i),  32'(line[i]), 32'(m_line[i]));
                    check($sformatf("cmp_busy%0d", i),  32'(busy[i]), 32'(m_busy[i]));
                    check($sformatf("cmp_ready%0d", i), 32'(rdy[i]),  32'(m_ready[i]));
                    check($sformatf("cmp_done%0d", i),  32'(done[i]), 32'(m_done[i]));
                end
            end
        end
    end

    // ---------------- recording and hooks ----------------
    logic rec_line  [4][100];
    logic rec_busy  [4][100];
    logic rec_ready [4][100];
    logic rec_done  [4][100];

    int         chg_at, drop_at, vset_at, drop2_at, rst_at;
    logic [7:0] chg_din;

    task automatic hooks(input int c_at, input logic [7:0] c_din, input int d_at,
                         input int v_at, input int d2_at, input int r_at);
        chg_at = c_at; chg_din = c_din; drop_at = d_at;
        vset_at = v_at; drop2_at = d2_at; rst_at = r_at;
    endtask

    task automatic record(input int n);
        for (int s = 1; s <= n; s++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rec_line[i][s]  = line[i];
                rec_busy[i][s]  = busy[i];
                rec_ready[i][s] = rdy[i];
                rec_done[i][s]  = done[i];
            end
            if (s == chg_at)   din = chg_din;
            if (s == drop_at)  vld = 4'b0000;
            if (s == vset_at)  vld = 4'b0001;
            if (s == drop2_at) vld = 4'b0000;
            if (s == rst_at)   rst = 1'b1;
            if (s == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic start(input logic [3:0] mask, input logic [7:0] d);
        int k;
        k = 0;
        while (((rdy & mask) != mask) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", 32'((rdy & mask) == mask), 32'd1);
        din = d;
        vld = mask;
    endtask

    function automatic int busy_cnt(input int i, input int n);
        int c = 0;
        for (int s = 1; s <= n; s++) c += int'(rec_busy[i][s]);
        return c;
    endfunction

    function automatic int done_cnt(input int i, input int n);
        int c = 0;
        for (int s = 1; s <= n; s++) c += int'(rec_done[i][s]);
        return c;
    endfunction

    function automatic int done_first(input int i, input int n);
        for (int s = 1; s <= n; s++) if (rec_done[i][s]) return s;
        return -1;
    endfunction

    function automatic logic [9:0] centers(input int i, input int first);
        logic [9:0] v;
        for (int k = 0; k < 10; k++) v[k] = rec_line[i][first + 4 * k];
        return v;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; vld = 4'b0000; din = 8'h00;
        hooks(-1, 8'h00, -1, -1, -1, -5);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_line",  32'(line[0]), 32'd1);
        check("rst_busy",  32'(busy[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]),  32'd0);
        check("rst_done",  32'(done[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(rdy[0]), 32'd1);

        // Round A: 0xA5 on all four.
        hooks(-1, 8'h00, 1, -1, -1, -5);
        start(4'b1111, 8'hA5);
        record(50);
        check("A_8n1_bits",    32'(centers(0, 2)), 32'(10'b1101001010));
        check("A_8n1_busy",    32'(busy_cnt(0, 50)), 32'd40);
        check("A_8n1_done_at", 32'(done_first(0, 50)), 32'd41);
        check("A_8n1_done_n",  32'(done_cnt(0, 50)), 32'd1);
        check("A_8e1_par",     32'(rec_line[1][38]), 32'd0);
        check("A_8e1_busy",    32'(busy_cnt(1, 50)), 32'd44);
        check("A_8o1_par",     32'(rec_line[2][38]), 32'd1);
        check("A_8o1_busy",    32'(busy_cnt(2, 50)), 32'd44);

        // Round B: 0x00.
        start(4'b1111, 8'h00);
        record(50);
        check("B_8o1_par", 32'(rec_line[2][38]), 32'd1);
        check("B_8e1_par", 32'(rec_line[1][38]), 32'd0);

        // Round C: 0x7F, 7N2 frame.
        start(4'b1111, 8'h7F);
        record(50);
        check("C_7n2_bits",    32'(centers(3, 2)), 32'(10'b1111111110));
        check("C_7n2_busy",    32'(busy_cnt(3, 50)), 32'd40);
        check("C_7n2_done_at", 32'(done_first(3, 50)), 32'd41);
        for (int s = 33; s <= 40; s++) check("C_7n2_stop", 32'(rec_line[3][s]), 32'd1);

        // Back-to-back on 8N1 with valid held and data changed mid-frame.
        hooks(5, 8'h0F, 42, -1, -1, -5);
        start(4'b0001, 8'h55);
        record(90);
        check("B2B_f1_bits",  32'(centers(0, 2)), 32'(10'b1010101010));
        check("B2B_gap_line", 32'(rec_line[0][41]), 32'd1);
        check("B2B_gap_busy", 32'(rec_busy[0][41]), 32'd0);
        check("B2B_start2",   32'(rec_line[0][42]), 32'd0);
        check("B2B_f2_bits",  32'(centers(0, 43)), 32'(10'b1000011110));
        check("B2B_done_n",   32'(done_cnt(0, 90)), 32'd2);
        check("B2B_done2",    32'(rec_done[0][82]), 32'd1);

        // Reset in the middle of a frame.
        hooks(-1, 8'h00, 1, -1, -1, 14);
        start(4'b0001, 8'hA5);
        record(60);
        check("RST_line",     32'(rec_line[0][15]), 32'd1);
        check("RST_busy",     32'(rec_busy[0][15]), 32'd0);
        check("RST_ready_lo", 32'(rec_ready[0][15]), 32'd0);
        check("RST_ready_hi", 32'(rec_ready[0][16]), 32'd1);
        check("RST_no_done",  32'(done_cnt(0, 60)), 32'd0);

        hooks(-1, 8'h00, 1, -1, -1, -5);
        start(4'b0001, 8'hA5);
        record(50);
        check("RST_next_bits", 32'(centers(0, 2)), 32'(10'b1101001010));
        check("RST_next_done", 32'(done_first(0, 50)), 32'd41);

        // Valid pulsed mid-frame is ignored.
        hooks(-1, 8'h00, 1, 10, 11, -5);
        start(4'b0001, 8'h3C);
        record(90);
        check("MV_done_n", 32'(done_cnt(0, 90)), 32'd1);
        check("MV_busy",   32'(busy_cnt(0, 90)), 32'd40);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
